// File: rtl/clcd_pkg.sv
// rtl/clcd_pkg.sv - shared constants, FSM states and address helpers for the CLCD responder
// Purpose: opcode constants, state enum, DDRAM line geometry and AC stepping helpers.
// Ports: none (package).
package clcd_pkg;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNCSET = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam int         LINE_LEN    = 16;
    localparam int         DDRAM_DEPTH = 32;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } clcd_state_t;

    // Next address counter value; the two lines form one 32-cell ring.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (ac[3:0] == 4'hF) r = ac[6] ? LINE0_BASE : LINE1_BASE;
            else                 r = ac + 7'd1;
        end else begin
            if (ac[3:0] == 4'h0) r = ac[6] ? (LINE0_BASE + 7'(LINE_LEN - 1))
                                           : (LINE1_BASE + 7'(LINE_LEN - 1));
            else                 r = ac - 7'd1;
        end
        return r;
    endfunction

    // DDRAM cell index: bit 4 selects the line, bits 3:0 the column.
    function automatic logic [4:0] ac_to_idx(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/clcd_responder_if.sv
// rtl/clcd_responder_if.sv - character-LCD bus between controller and display
// Purpose: groups the LCD strobe/control/data lines.
// Signals: LCD_E enable strobe, LCD_RS register select, LCD_RW direction,
//          LCD_DATA write data, LCD_DATA_OUT read data from the display.
interface clcd_responder_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic [7:0] LCD_DATA_OUT;

    modport master (
        output LCD_E, LCD_RS, LCD_RW, LCD_DATA,
        input  LCD_DATA_OUT
    );

    modport slave (
        input  LCD_E, LCD_RS, LCD_RW, LCD_DATA,
        output LCD_DATA_OUT
    );
endinterface

// File: rtl/clcd_ddram.sv
// rtl/clcd_ddram.sv - 32x8 display RAM with blank-character reset
// Purpose: register file holding both display lines.
// Ports: CLK, RESETN (async, active-high), i_we/i_waddr/i_wdata write port,
//        i_raddr_a/o_rdata_a and i_raddr_b/o_rdata_b combinational read ports.
module clcd_ddram
    import clcd_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_raddr_a,
    output logic [7:0] o_rdata_a,
    input  logic [4:0] i_raddr_b,
    output logic [7:0] o_rdata_b
);
    logic [7:0] r_mem [DDRAM_DEPTH];

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            for (int i = 0; i < DDRAM_DEPTH; i++) r_mem[i] <= BLANK_CHAR;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/clcd_responder.sv
// rtl/clcd_responder.sv - HD44780-style display model answering the CLCD bus
// Purpose: accepts transfers on LCD_E falling edges, decodes instructions and
//          data accesses, keeps DDRAM/AC/mode flags and models the busy flag.
// Ports: CLK, RESETN (async, active-high), lcd (bus, slave side), RD_ADDR/RD_CHAR
//        debug read, AC, BUSY, display/entry/function flags, CMD_STROBE, ERR_*.
module clcd_responder
    import clcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 4,
    parameter int HOME_CYCLES = 16
) (
    input  logic            RESETN,
    input  logic            CLK,
    clcd_responder_if.slave lcd,
    input  logic [4:0]      RD_ADDR,
    output logic [7:0]      RD_CHAR,
    output logic [6:0]      AC,
    output logic            BUSY,
    output logic            DISP_ON,
    output logic            CURSOR_ON,
    output logic            BLINK_ON,
    output logic            INC_MODE,
    output logic            SHIFT_MODE,
    output logic            FUNC_8BIT,
    output logic            FUNC_2LINE,
    output logic            CMD_STROBE,
    output logic            ERR_BUSY,
    output logic            ERR_ADDR,
    output logic            ERR_UNSUP
);
    clcd_state_t r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [5:0]  r_fill, w_fill_nxt;
    logic [6:0]  r_ac, w_ac_nxt;
    logic [7:0]  r_dout, w_dout_nxt;
    logic        r_e_q, r_strobe, w_strobe_nxt;
    logic        r_disp, r_cur, r_blink, r_inc, r_shift, r_f8, r_f2;
    logic        r_eb, r_ea, r_eu;
    logic        w_set_eb, w_set_ea, w_set_eu;
    logic        w_entry_ld, w_disp_ld, w_func_ld, w_clr_done;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [7:0]  w_wdata, w_rd_ac;
    logic        w_fall, w_status, w_busy;

    assign w_fall   = r_e_q & ~lcd.LCD_E;
    assign w_status = ~lcd.LCD_RS & lcd.LCD_RW;
    assign w_busy   = (r_state != IDLE);

    clcd_ddram u_ddram (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (ac_to_idx(r_ac)),
        .o_rdata_a (w_rd_ac),
        .i_raddr_b (RD_ADDR),
        .o_rdata_b (RD_CHAR)
    );

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_fill_nxt   = r_fill;
        w_ac_nxt     = r_ac;
        w_dout_nxt   = r_dout;
        w_strobe_nxt = 1'b0;
        w_we         = 1'b0;
        w_waddr      = ac_to_idx(r_ac);
        w_wdata      = lcd.LCD_DATA;
        w_set_eb     = 1'b0;
        w_set_ea     = 1'b0;
        w_set_eu     = 1'b0;
        w_entry_ld   = 1'b0;
        w_disp_ld    = 1'b0;
        w_func_ld    = 1'b0;
        w_clr_done   = 1'b0;

        // Status reads are served in every state, so they sit outside the FSM.
        if (w_fall && w_status) begin
            w_strobe_nxt = 1'b1;
            w_dout_nxt   = {w_busy, r_ac};
        end

        case (r_state)
            IDLE: begin
                if (w_fall && !w_status) begin
                    w_strobe_nxt = 1'b1;
                    w_state_nxt  = EXEC;
                    w_cnt_nxt    = 16'(BUSY_CYCLES - 1);
                    if (lcd.LCD_RS) begin
                        if (lcd.LCD_RW) w_dout_nxt = w_rd_ac;
                        else            w_we       = 1'b1;
                        w_ac_nxt = ac_step(r_ac, r_inc);
                    end else begin
                        casez (lcd.LCD_DATA)
                            8'b1???????: begin
                                if (lcd.LCD_DATA[5:4] != 2'b00) w_set_ea = 1'b1;
                                else                            w_ac_nxt = lcd.LCD_DATA[6:0];
                            end
                            8'b01??????: w_set_eu  = 1'b1;
                            8'b001?????: w_func_ld = 1'b1;
                            8'b0001????: begin
                                if (!lcd.LCD_DATA[3]) w_ac_nxt = ac_step(r_ac, lcd.LCD_DATA[2]);
                            end
                            8'b00001???: w_disp_ld  = 1'b1;
                            8'b000001??: w_entry_ld = 1'b1;
                            8'b0000001?: begin
                                w_ac_nxt  = LINE0_BASE;
                                w_cnt_nxt = 16'(HOME_CYCLES - 1);
                            end
                            8'b00000001: begin
                                // Cell 0 is blanked on the accepting edge; CLEAR does 1..31.
                                w_state_nxt = CLEAR;
                                w_fill_nxt  = 6'd1;
                                w_we        = 1'b1;
                                w_waddr     = 5'd0;
                                w_wdata     = BLANK_CHAR;
                            end
                            default: w_state_nxt = IDLE;
                        endcase
                    end
                end
            end
            EXEC: begin
                if (w_fall && !w_status) w_set_eb = 1'b1;
                if (r_cnt == 16'd0) w_state_nxt = IDLE;
                else                w_cnt_nxt   = r_cnt - 16'd1;
            end
            CLEAR: begin
                if (w_fall && !w_status) w_set_eb = 1'b1;
                // Fill counts 1..32; the 32nd cycle writes nothing and hands over to EXEC.
                if (!r_fill[5]) begin
                    w_we       = 1'b1;
                    w_waddr    = r_fill[4:0];
                    w_wdata    = BLANK_CHAR;
                    w_fill_nxt = r_fill + 6'd1;
                end else begin
                    w_state_nxt = EXEC;
                    w_cnt_nxt   = 16'(HOME_CYCLES - 1);
                    w_ac_nxt    = LINE0_BASE;
                    w_clr_done  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            r_cnt    <= '0;
            r_fill   <= '0;
            r_ac     <= LINE0_BASE;
            r_dout   <= '0;
            r_e_q    <= 1'b0;
            r_strobe <= 1'b0;
            r_disp   <= 1'b0;
            r_cur    <= 1'b0;
            r_blink  <= 1'b0;
            r_inc    <= 1'b1;
            r_shift  <= 1'b0;
            r_f8     <= 1'b1;
            r_f2     <= 1'b0;
            r_eb     <= 1'b0;
            r_ea     <= 1'b0;
            r_eu     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_fill   <= w_fill_nxt;
            r_ac     <= w_ac_nxt;
            r_dout   <= w_dout_nxt;
            r_e_q    <= lcd.LCD_E;
            r_strobe <= w_strobe_nxt;
            if (w_set_eb) r_eb <= 1'b1;
            if (w_set_ea) r_ea <= 1'b1;
            if (w_set_eu) r_eu <= 1'b1;
            if (w_entry_ld) begin
                r_inc   <= lcd.LCD_DATA[1];
                r_shift <= lcd.LCD_DATA[0];
            end
            if (w_clr_done) r_inc <= 1'b1;
            if (w_disp_ld) {r_disp, r_cur, r_blink} <= lcd.LCD_DATA[2:0];
            if (w_func_ld) {r_f8, r_f2} <= lcd.LCD_DATA[4:3];
        end
    end

    assign lcd.LCD_DATA_OUT = r_dout;
    assign AC         = r_ac;
    assign BUSY       = w_busy;
    assign DISP_ON    = r_disp;
    assign CURSOR_ON  = r_cur;
    assign BLINK_ON   = r_blink;
    assign INC_MODE   = r_inc;
    assign SHIFT_MODE = r_shift;
    assign FUNC_8BIT  = r_f8;
    assign FUNC_2LINE = r_f2;
    assign CMD_STROBE = r_strobe;
    assign ERR_BUSY   = r_eb;
    assign ERR_ADDR   = r_ea;
    assign ERR_UNSUP  = r_eu;
endmodule

// File: tb/tb_clcd_responder.sv
// tb/tb_clcd_responder.sv - directed and randomized checks of clcd_responder
module tb_clcd_responder;
    localparam int BC = 4;
    localparam int HC = 16;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic [4:0] RD_ADDR = '0;
    logic [7:0] RD_CHAR;
    logic [6:0] AC;
    logic       BUSY, DISP_ON, CURSOR_ON, BLINK_ON, INC_MODE, SHIFT_MODE;
    logic       FUNC_8BIT, FUNC_2LINE, CMD_STROBE, ERR_BUSY, ERR_ADDR, ERR_UNSUP;

    clcd_responder_if lcd();

    clcd_responder #(.BUSY_CYCLES(BC), .HOME_CYCLES(HC)) dut (
        .RESETN(RESETN), .CLK(CLK), .lcd(lcd),
        .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR), .AC(AC), .BUSY(BUSY),
        .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON), .BLINK_ON(BLINK_ON),
        .INC_MODE(INC_MODE), .SHIFT_MODE(SHIFT_MODE),
        .FUNC_8BIT(FUNC_8BIT), .FUNC_2LINE(FUNC_2LINE), .CMD_STROBE(CMD_STROBE),
        .ERR_BUSY(ERR_BUSY), .ERR_ADDR(ERR_ADDR), .ERR_UNSUP(ERR_UNSUP)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: display as a 32-position ring, AC derived from position.
    logic [7:0] m_mem [32];
    int         m_pos;
    bit m_disp, m_cur, m_blink, m_inc, m_shift, m_f8, m_f2, m_eb, m_ea, m_eu;

    wire [9:0] dut_flags = {DISP_ON, CURSOR_ON, BLINK_ON, INC_MODE, SHIFT_MODE,
                            FUNC_8BIT, FUNC_2LINE, ERR_BUSY, ERR_ADDR, ERR_UNSUP};

    function automatic logic [6:0] m_ac();
        return 7'((m_pos / 16) * 64 + (m_pos % 16));
    endfunction

    function automatic logic [9:0] m_flags();
        return {m_disp, m_cur, m_blink, m_inc, m_shift, m_f8, m_f2, m_eb, m_ea, m_eu};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_pos = 0;
        {m_disp, m_cur, m_blink, m_shift, m_f2, m_eb, m_ea, m_eu} = '0;
        m_inc = 1; m_f8 = 1;
    endtask

    task automatic m_step(input bit up);
        m_pos = up ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
    endtask

    task automatic m_apply(input logic rs, input logic rw, input logic [7:0] d,
                           output int blen, output logic [7:0] dout, output bit rd);
        blen = BC; dout = 8'h00; rd = 0;
        if (rs && !rw) begin
            m_mem[m_pos] = d; m_step(m_inc);
        end else if (rs && rw) begin
            dout = m_mem[m_pos]; rd = 1; m_step(m_inc);
        end else if (rw) begin
            dout = {1'b0, m_ac()}; rd = 1; blen = 0;
        end else if (d >= 8'h80) begin
            if (d[5:4] != 2'b00) m_ea = 1;
            else m_pos = (d[6] ? 16 : 0) + int'(d[3:0]);
        end else if (d >= 8'h40) m_eu = 1;
        else if (d >= 8'h20) begin m_f8 = d[4]; m_f2 = d[3]; end
        else if (d >= 8'h10) begin if (!d[3]) m_step(d[2]); end
        else if (d >= 8'h08) {m_disp, m_cur, m_blink} = d[2:0];
        else if (d >= 8'h04) begin m_inc = d[1]; m_shift = d[0]; end
        else if (d >= 8'h02) begin m_pos = 0; blen = HC; end
        else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_pos = 0; m_inc = 1; blen = 32 + HC;
        end else blen = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input int a, output logic [7:0] v);
        RD_ADDR = 5'(a);
        #1;
        v = RD_CHAR;
    endtask

    task automatic check_mem(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            chk($sformatf("%s:cell%0d", tag, i), v, m_mem[i]);
        end
    endtask

    // Returns at the sample point of the cycle after the accepting edge.
    task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge CLK);
        lcd.LCD_E = 1'b1; lcd.LCD_RS = rs; lcd.LCD_RW = rw; lcd.LCD_DATA = d;
        @(negedge CLK);
        lcd.LCD_E = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (BUSY !== 1'b0 && c < 200) begin c++; @(negedge CLK); end
        chk({tag, ":idle"}, BUSY, 0);
    endtask

    task automatic op(input string tag, input logic rs, input logic rw, input logic [7:0] d);
        int blen, c;
        logic [7:0] edout;
        bit rd;
        m_apply(rs, rw, d, blen, edout, rd);
        pulse(rs, rw, d);
        chk({tag, ":strobe"}, CMD_STROBE, 1);
        if (rd) chk({tag, ":dout"}, lcd.LCD_DATA_OUT, edout);
        c = 0;
        while (BUSY === 1'b1 && c < 200) begin c++; @(negedge CLK); end
        chk({tag, ":busylen"}, c, blen);
        chk({tag, ":ac"}, AC, m_ac());
        chk({tag, ":flags"}, dut_flags, m_flags());
    endtask

    initial begin
        logic [7:0] v, d;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        lcd.LCD_E = 0; lcd.LCD_RS = 0; lcd.LCD_RW = 0; lcd.LCD_DATA = 0;
        m_reset();
        repeat (3) @(negedge CLK);
        RESETN = 0;
        @(negedge CLK);

        chk("rst:ac", AC, 0);
        chk("rst:busy", BUSY, 0);
        chk("rst:flags", dut_flags, 10'b0001010000);
        chk("rst:strobe", CMD_STROBE, 0);
        chk("rst:dout", lcd.LCD_DATA_OUT, 0);
        check_mem("rst");

        op("init38", 0, 0, 8'h38);
        op("init0C", 0, 0, 8'h0C);
        op("init06", 0, 0, 8'h06);
        op("init01", 0, 0, 8'h01);
        chk("init:f2", FUNC_2LINE, 1);
        chk("init:disp", DISP_ON, 1);
        chk("init:cur", CURSOR_ON, 0);
        chk("init:inc", INC_MODE, 1);
        chk("init:ac", AC, 0);
        check_mem("init");

        op("addr80", 0, 0, 8'h80);
        for (int i = 0; i < 5; i++) op("hello", 1, 0, hello[i]);
        for (int i = 0; i < 5; i++) begin
            peek(i, v);
            chk($sformatf("hello:cell%0d", i), v, hello[i]);
        end
        chk("hello:ac", AC, 7'h05);

        op("addr8F", 0, 0, 8'h8F);
        op("wrA", 1, 0, 8'h41);
        op("wrB", 1, 0, 8'h42);
        peek(15, v); chk("wrap:cell15", v, 8'h41);
        peek(16, v); chk("wrap:cell16", v, 8'h42);
        chk("wrap:ac", AC, 7'h41);
        op("entry04", 0, 0, 8'h04);
        op("addrC0", 0, 0, 8'hC0);
        op("wrC", 1, 0, 8'h43);
        chk("dec:ac", AC, 7'h0F);

        // Status read while busy is answered with the busy bit set.
        begin
            int bl; logic [7:0] ed; bit rd;
            m_apply(1, 0, 8'h5A, bl, ed, rd);
            pulse(1, 0, 8'h5A);
            pulse(0, 1, 8'h00);
            chk("stbusy:strobe", CMD_STROBE, 1);
            chk("stbusy:dout", lcd.LCD_DATA_OUT, {1'b1, m_ac()});
            wait_idle("stbusy");

            m_apply(1, 0, 8'h11, bl, ed, rd);
            pulse(1, 0, 8'h11);
            pulse(1, 0, 8'h22);
            m_eb = 1;
            chk("rej:strobe", CMD_STROBE, 0);
            chk("rej:errbusy", ERR_BUSY, 1);
            chk("rej:ac", AC, m_ac());
            wait_idle("rej");
            check_mem("rej");
        end

        op("badaddr", 0, 0, 8'h90);
        chk("badaddr:err", ERR_ADDR, 1);
        op("cgram", 0, 0, 8'h40);
        chk("cgram:err", ERR_UNSUP, 1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op("rnd_wr", 1, 0, 8'($urandom));
                3:       op("rnd_rd", 1, 1, 8'h00);
                4: begin
                    d = 8'h80 | 8'($urandom_range(0, 127));
                    if ($urandom_range(0, 3) != 0) d[5:4] = 2'b00;
                    op("rnd_addr", 0, 0, d);
                end
                5: op("rnd_entry", 0, 0, 8'h04 | 8'($urandom_range(0, 3)));
                6: op("rnd_shift", 0, 0, 8'h10 | 8'($urandom_range(0, 15)));
                7: op("rnd_disp",  0, 0, 8'h08 | 8'($urandom_range(0, 7)));
                8: op("rnd_func",  0, 0, 8'h20 | 8'($urandom_range(0, 31)));
                default: begin
                    case ($urandom_range(0, 4))
                        0: op("rnd_nop",    0, 0, 8'h00);
                        1: op("rnd_home",   0, 0, 8'h02 | 8'($urandom_range(0, 1)));
                        2: op("rnd_status", 0, 1, 8'($urandom));
                        3: op("rnd_cgram",  0, 0, 8'h40 | 8'($urandom_range(0, 63)));
                        default: op("rnd_clear", 0, 0, 8'h01);
                    endcase
                end
            endcase
        end
        check_mem("rnd");

        op("fill06", 0, 0, 8'h06);
        op("fill80", 0, 0, 8'h80);
        for (int i = 0; i < 32; i++) op("fill", 1, 0, 8'h41);
        pulse(0, 0, 8'h01);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge CLK);
            peek(k, v);     chk($sformatf("clr:cell%0d", k), v, 8'h20);
            peek(k + 1, v); chk($sformatf("clr:next%0d", k + 1), v, 8'h41);
        end
        RESETN = 1;
        #1;
        m_reset();
        chk("midrst:busy", BUSY, 0);
        chk("midrst:ac", AC, 0);
        chk("midrst:flags", dut_flags, m_flags());
        chk("midrst:strobe", CMD_STROBE, 0);
        chk("midrst:dout", lcd.LCD_DATA_OUT, 0);
        check_mem("midrst");
        @(negedge CLK);
        RESETN = 0;
        @(negedge CLK);
        chk("postrst:busy", BUSY, 0);
        chk("postrst:flags", dut_flags, m_flags());
        op("postrst_wr", 1, 0, 8'h7E);
        check_mem("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
